// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port arbiter and RV32 access sequencer for the data memory
module data_memory_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_request,
    input  logic                  p0_write,
    input  logic [2:0]            p0_funct3,
    input  logic [31:0]           p0_address,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_grant,
    output logic                  p0_done,
    output logic                  p0_error,
    output logic [31:0]           p0_rdata,
    input  logic                  p1_request,
    input  logic                  p1_write,
    input  logic [2:0]            p1_funct3,
    input  logic [31:0]           p1_address,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_grant,
    output logic                  p1_done,
    output logic                  p1_error,
    output logic [31:0]           p1_rdata,
    output logic [ADDR_WIDTH-3:0] mem_address,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [31:0]           mem_q
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_write;
    logic                  r_error;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;
    logic [ADDR_WIDTH-3:0] r_mem_address;
    logic [3:0]            r_mem_byteena;
    logic [31:0]           r_mem_data;
    logic                  r_mem_rden;
    logic                  r_mem_wren;
    logic [31:0]           r_p0_rdata;
    logic [31:0]           r_p1_rdata;

    logic                  w_any;
    logic                  w_sel;
    logic                  w_write;
    logic                  w_illegal;
    logic [2:0]            w_funct3;
    logic [31:0]           w_address;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be_base;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load;

    assign w_any = p0_request | p1_request;

    // On a tie the port that was not served last wins, unless port 0 has fixed priority.
    always_comb begin
        w_sel = p1_request;
        if (p0_request && p1_request) begin
            w_sel = FIXED_PRIORITY ? 1'b0 : ~r_last_grant;
        end
    end

    assign w_write   = w_sel ? p1_write   : p0_write;
    assign w_funct3  = w_sel ? p1_funct3  : p0_funct3;
    assign w_address = w_sel ? p1_address : p0_address;
    assign w_wdata   = w_sel ? p1_wdata   : p0_wdata;

    always_comb begin
        w_illegal = 1'b0;
        case (w_funct3)
            3'b001, 3'b101:         w_illegal = w_address[0];
            3'b010:                 w_illegal = |w_address[1:0];
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = 1'b0;
        endcase
        if (w_write && w_funct3[2]) begin
            w_illegal = 1'b1;
        end
        if ((w_address >> ADDR_WIDTH) != 32'd0) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        case (w_funct3[1:0])
            2'b00:   w_be_base = 4'b0001;
            2'b01:   w_be_base = 4'b0011;
            default: w_be_base = 4'b1111;
        endcase
    end

    assign w_shifted = mem_q >> {r_offset, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next_state = r_write ? S_RESP : S_WAIT;
            S_WAIT:  w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobes are registered so they are high for exactly the ISSUE cycle; the
    // address/enable/data registers only reload on a legal capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_write       <= 1'b0;
            r_error       <= 1'b0;
            r_funct3      <= 3'd0;
            r_offset      <= 2'd0;
            r_mem_address <= '0;
            r_mem_byteena <= 4'd0;
            r_mem_data    <= 32'd0;
            r_mem_rden    <= 1'b0;
            r_mem_wren    <= 1'b0;
            r_p0_rdata    <= 32'd0;
            r_p1_rdata    <= 32'd0;
        end else begin
            r_mem_rden <= 1'b0;
            r_mem_wren <= 1'b0;
            if (r_state == S_IDLE && w_any) begin
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
                r_write      <= w_write;
                r_funct3     <= w_funct3;
                r_offset     <= w_address[1:0];
                r_error      <= w_illegal;
                if (!w_illegal) begin
                    r_mem_address <= w_address[ADDR_WIDTH-1:2];
                    r_mem_byteena <= w_be_base << w_address[1:0];
                    r_mem_data    <= w_wdata << {w_address[1:0], 3'b000};
                    r_mem_rden    <= ~w_write;
                    r_mem_wren    <= w_write;
                end
            end
            if (r_state == S_WAIT) begin
                if (r_owner) begin
                    r_p1_rdata <= w_load;
                end else begin
                    r_p0_rdata <= w_load;
                end
            end
        end
    end

    assign p0_grant    = !reset && (r_state == S_IDLE) && w_any && !w_sel;
    assign p1_grant    = !reset && (r_state == S_IDLE) && w_any && w_sel;
    assign p0_done     = !reset && (r_state == S_RESP) && !r_owner;
    assign p1_done     = !reset && (r_state == S_RESP) && r_owner;
    assign p0_error    = p0_done && r_error;
    assign p1_error    = p1_done && r_error;
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;
    assign mem_address = r_mem_address;
    assign mem_byteena = r_mem_byteena;
    assign mem_data    = r_mem_data;
    assign mem_rden    = r_mem_rden;
    assign mem_wren    = r_mem_wren;

endmodule
